// File: rtl/md5_job_pkg.sv
// Shared constants, register map and FSM encoding for the MD5 brute-force job controller.
package md5_job_pkg;

  localparam int unsigned MAX_PREFIX   = 51;
  localparam int unsigned BF_SYMBOLS   = 4;
  localparam logic [7:0]  PAD_BYTE     = 8'h80;
  localparam int unsigned BLOCK_W      = 512;
  localparam int unsigned PREFIX_WORDS = 13;
  localparam int unsigned RESULT_WORDS = 16;

  // Word addresses
  localparam int unsigned A_CTRL       = 32'h00;
  localparam int unsigned A_STATUS     = 32'h01;
  localparam int unsigned A_HASH_A     = 32'h02;
  localparam int unsigned A_HASH_D     = 32'h05;
  localparam int unsigned A_PREFIX_LEN = 32'h06;
  localparam int unsigned A_CYCLES     = 32'h07;
  localparam int unsigned A_PREFIX     = 32'h10;
  localparam int unsigned A_RESULT     = 32'h20;

  // STATUS bit positions
  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_FOUND     = 1;
  localparam int unsigned ST_EXHAUSTED = 2;
  localparam int unsigned ST_ABORTED   = 3;
  localparam int unsigned ST_LEN_ERR   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_FOUND,
    S_EXHAUSTED,
    S_ABORTED
  } state_t;

endpackage

// File: rtl/md5_job_ctrl_pad.sv
// Combinational MD5 single-block formatter: prefix, seeded symbol slots, 0x80 pad, bit length.
module md5_pad_block
  import md5_job_pkg::*;
#(
  parameter logic [7:0] SEED_CHAR = 8'h20
) (
  input  logic [PREFIX_WORDS*32-1:0] prefix,
  input  logic [5:0]                 prefix_len,
  output logic [BLOCK_W-1:0]         block
);

  int unsigned p;

  always_comb begin
    block = '0;
    p     = 32'(prefix_len);
    for (int unsigned i = 0; i < PREFIX_WORDS * 4; i++) begin
      if (i < p) block[8*i +: 8] = prefix[8*i +: 8];
    end
    // Symbol slots and pad byte follow the prefix; bytes 56..63 carry the length
    for (int unsigned i = 0; i < 56; i++) begin
      if (i >= p && i < p + BF_SYMBOLS) block[8*i +: 8] = SEED_CHAR;
      else if (i == p + BF_SYMBOLS)     block[8*i +: 8] = PAD_BYTE;
    end
    block[511:448] = 64'((p + BF_SYMBOLS) * 32'd8);
  end

endmodule

// File: rtl/md5_job_ctrl.sv
// Register-mapped job controller for the 4-symbol MD5 brute-force engine.
// Optional RUN-cycle counter at 0x07 enabled by defining MD5_JOB_CYCLE_CNT_EN.
module md5_job_ctrl #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned MAX_PREFIX = md5_job_pkg::MAX_PREFIX,
  parameter logic [7:0]  SEED_CHAR  = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              irq,
  output logic              bf_ce,
  output logic              bf_reset,
  output logic              bf_reset_zero_string,
  output logic [511:0]      bf_start_str,
  output logic [31:0]       bf_a_hash,
  output logic [31:0]       bf_b_hash,
  output logic [31:0]       bf_c_hash,
  output logic [31:0]       bf_d_hash,
  input  logic              bf_find_str,
  input  logic              bf_symbols_done,
  input  logic [511:0]      bf_result_str
);
  import md5_job_pkg::*;

  state_t      state;
  logic [31:0] a;
  logic [31:0] hash   [4];
  logic [31:0] prefix [PREFIX_WORDS];
  logic [31:0] result [RESULT_WORDS];
  logic [5:0]  prefix_len;
  logic [PREFIX_WORDS*32-1:0] prefix_flat;
  logic [BLOCK_W-1:0]         pad_block;
  logic        found, exhausted, aborted, len_err;
  logic        busy, ctrl_wr, start_req, abort_req, len_ok;
  logic [4:0]  status;
  logic [31:0] rd_next;

  assign a         = 32'(addr);
  assign busy      = (state == S_ARM) || (state == S_RUN);
  assign ctrl_wr   = wr_en && (a == A_CTRL);
  assign start_req = ctrl_wr && wr_data[0] && !busy;
  assign abort_req = ctrl_wr && wr_data[1];
  assign len_ok    = prefix_len <= 6'(MAX_PREFIX);

  assign bf_a_hash = hash[0];
  assign bf_b_hash = hash[1];
  assign bf_c_hash = hash[2];
  assign bf_d_hash = hash[3];

  always_comb begin
    prefix_flat = '0;
    for (int unsigned k = 0; k < PREFIX_WORDS; k++) prefix_flat[32*k +: 32] = prefix[k];
  end

  md5_pad_block #(.SEED_CHAR(SEED_CHAR)) u_pad (
    .prefix     (prefix_flat),
    .prefix_len (prefix_len),
    .block      (pad_block)
  );

  // Software-writable job parameters, frozen while a job is in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < 4; k++) hash[k] <= '0;
      for (int unsigned k = 0; k < PREFIX_WORDS; k++) prefix[k] <= '0;
      prefix_len <= '0;
    end else if (wr_en && !busy) begin
      if (a >= A_HASH_A && a <= A_HASH_D)
        hash[2'(a - A_HASH_A)] <= wr_data;
      else if (a == A_PREFIX_LEN)
        prefix_len <= wr_data[5:0];
      else if (a >= A_PREFIX && a < A_PREFIX + PREFIX_WORDS)
        prefix[4'(a - A_PREFIX)] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      bf_ce                <= 1'b0;
      bf_reset             <= 1'b1;
      bf_reset_zero_string <= 1'b0;
      bf_start_str         <= '0;
      irq                  <= 1'b0;
      found                <= 1'b0;
      exhausted            <= 1'b0;
      aborted              <= 1'b0;
      len_err              <= 1'b0;
      for (int unsigned k = 0; k < RESULT_WORDS; k++) result[k] <= '0;
    end else begin
      case (state)
        S_ARM: begin
          state                <= S_RUN;
          bf_ce                <= 1'b1;
          bf_reset             <= 1'b0;
          bf_reset_zero_string <= 1'b0;
        end
        S_RUN: begin
          if (bf_find_str) begin
            state <= S_FOUND;
            found <= 1'b1;
            for (int unsigned k = 0; k < RESULT_WORDS; k++)
              result[k] <= bf_result_str[32*k +: 32];
          end else if (bf_symbols_done) begin
            state     <= S_EXHAUSTED;
            exhausted <= 1'b1;
          end else if (abort_req) begin
            state   <= S_ABORTED;
            aborted <= 1'b1;
          end
          if (bf_find_str || bf_symbols_done || abort_req) begin
            bf_ce    <= 1'b0;
            bf_reset <= 1'b1;
            irq      <= 1'b1;
          end
        end
        default: begin
          // IDLE and the three terminal states all accept a new job
          if (start_req) begin
            if (len_ok) begin
              state                <= S_ARM;
              bf_reset_zero_string <= 1'b1;
              bf_start_str         <= pad_block;
              irq                  <= 1'b0;
              found                <= 1'b0;
              exhausted            <= 1'b0;
              aborted              <= 1'b0;
              len_err              <= 1'b0;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef MD5_JOB_CYCLE_CNT_EN
  logic [31:0] cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               cycles <= '0;
    else if (start_req && len_ok)            cycles <= '0;
    else if (state == S_RUN && cycles != '1) cycles <= cycles + 32'd1;
  end
`endif

  always_comb begin
    status               = '0;
    status[ST_BUSY]      = busy;
    status[ST_FOUND]     = found;
    status[ST_EXHAUSTED] = exhausted;
    status[ST_ABORTED]   = aborted;
    status[ST_LEN_ERR]   = len_err;
  end

  always_comb begin
    rd_next = '0;
    if (a == A_STATUS)
      rd_next = 32'(status);
    else if (a >= A_HASH_A && a <= A_HASH_D)
      rd_next = hash[2'(a - A_HASH_A)];
    else if (a == A_PREFIX_LEN)
      rd_next = 32'(prefix_len);
`ifdef MD5_JOB_CYCLE_CNT_EN
    else if (a == A_CYCLES)
      rd_next = cycles;
`endif
    else if (a >= A_PREFIX && a < A_PREFIX + PREFIX_WORDS)
      rd_next = prefix[4'(a - A_PREFIX)];
    else if (a >= A_RESULT && a < A_RESULT + RESULT_WORDS)
      rd_next = result[4'(a - A_RESULT)];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= rd_next;
  end

endmodule

// File: tb/tb_md5_job_ctrl.sv
// Scoreboard bench for md5_job_ctrl: register reads queued with expected values, engine handshakes driven by hand.
module tb_md5_job_ctrl;

  localparam logic [5:0] R_CTRL   = 6'h00;
  localparam logic [5:0] R_STATUS = 6'h01;
  localparam logic [5:0] R_HASH_A = 6'h02;
  localparam logic [5:0] R_HASH_B = 6'h03;
  localparam logic [5:0] R_HASH_C = 6'h04;
  localparam logic [5:0] R_HASH_D = 6'h05;
  localparam logic [5:0] R_PLEN   = 6'h06;
  localparam logic [5:0] R_CYCLES = 6'h07;
  localparam logic [5:0] R_PFX0   = 6'h10;
  localparam logic [5:0] R_RES0   = 6'h20;
  localparam logic [5:0] R_RES1   = 6'h21;
  localparam logic [5:0] R_RES14  = 6'h2E;

`ifdef MD5_JOB_CYCLE_CNT_EN
  localparam logic [31:0] CYC_JOB2 = 32'd4;
  localparam logic [31:0] CYC_LAST = 32'd1;
`else
  localparam logic [31:0] CYC_JOB2 = 32'd0;
  localparam logic [31:0] CYC_LAST = 32'd0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [5:0]   addr = '0;
  logic [31:0]  wr_data = '0;
  logic [31:0]  rd_data;
  logic         irq, bf_ce, bf_reset, bf_reset_zero_string;
  logic [511:0] bf_start_str;
  logic [31:0]  bf_a_hash, bf_b_hash, bf_c_hash, bf_d_hash;
  logic         bf_find_str = 1'b0;
  logic         bf_symbols_done = 1'b0;
  logic [511:0] bf_result_str = '0;

  logic [31:0]  exp_q [$];
  string        name_q [$];
  logic         rd_pend;
  int           total = 0;
  int           bad = 0;
  logic [511:0] res1, res2;

  md5_job_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .wr_en                (wr_en),
    .rd_en                (rd_en),
    .addr                 (addr),
    .wr_data              (wr_data),
    .rd_data              (rd_data),
    .irq                  (irq),
    .bf_ce                (bf_ce),
    .bf_reset             (bf_reset),
    .bf_reset_zero_string (bf_reset_zero_string),
    .bf_start_str         (bf_start_str),
    .bf_a_hash            (bf_a_hash),
    .bf_b_hash            (bf_b_hash),
    .bf_c_hash            (bf_c_hash),
    .bf_d_hash            (bf_d_hash),
    .bf_find_str          (bf_find_str),
    .bf_symbols_done      (bf_symbols_done),
    .bf_result_str        (bf_result_str)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    chk(n, 64'(act), 64'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] e, input string n);
    rd_en = 1'b1; addr = a;
    exp_q.push_back(e); name_q.push_back(n);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wrrd(input logic [5:0] a, input logic [31:0] d, input logic [31:0] e, input string n);
    wr_en = 1'b1; rd_en = 1'b1; addr = a; wr_data = d;
    exp_q.push_back(e); name_q.push_back(n);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // Read data is valid the cycle after the strobe is sampled
  always @(posedge clk or posedge reset) begin
    if (reset) rd_pend <= 1'b0;
    else       rd_pend <= rd_en;
  end

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got %h expected none", rd_data);
      end else begin
        chk(name_q.pop_front(), 64'(rd_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res1 = '0;
    res1[31:0]    = 32'h77636261;
    res1[63:32]   = 32'h807a7978;
    res1[479:448] = 32'h00000038;
    res2 = '0;
    res2[31:0]    = 32'h11223344;

    reset = 1'b1;
    tick(); tick();
    chk1("rst_ce", bf_ce, 1'b0);
    chk1("rst_bf_reset", bf_reset, 1'b1);
    chk1("rst_zero_string", bf_reset_zero_string, 1'b0);
    chk1("rst_irq", irq, 1'b0);
    chk1("rst_start_str", |bf_start_str, 1'b0);
    reset = 1'b0;
    tick();
    rd(R_STATUS, 32'h0, "status_after_reset");
    rd(R_HASH_A, 32'h0, "hash_a_after_reset");

    // Oversized prefix is rejected
    wr(R_PLEN, 32'd52);
    wr(R_CTRL, 32'h1);
    chk1("lenerr_ce", bf_ce, 1'b0);
    chk1("lenerr_zero_string", bf_reset_zero_string, 1'b0);
    tick();
    chk1("lenerr_ce_later", bf_ce, 1'b0);
    rd(R_STATUS, 32'h10, "status_len_err");

    // P=0 job, then abort
    wr(R_HASH_A, 32'h4c71fce2);
    wr(R_HASH_B, 32'h93ee2747);
    wr(R_HASH_C, 32'hcd24f395);
    wr(R_HASH_D, 32'h1f337f2e);
    wrrd(R_PLEN, 32'd0, 32'd52, "plen_same_cycle_old");
    rd(R_PLEN, 32'd0, "plen_new");
    rd(R_HASH_C, 32'hcd24f395, "hash_c_readback");
    chk("bf_a_hash", 64'(bf_a_hash), 64'h4c71fce2);
    chk("bf_d_hash", 64'(bf_d_hash), 64'h1f337f2e);
    wr(R_CTRL, 32'h1);
    chk1("arm_zero_string", bf_reset_zero_string, 1'b1);
    chk1("arm_bf_reset", bf_reset, 1'b1);
    chk1("arm_ce", bf_ce, 1'b0);
    chk("p0_block_lo", bf_start_str[63:0], 64'h00000080_20202020);
    chk("p0_block_len", bf_start_str[511:448], 64'h20);
    chk1("p0_block_mid", |bf_start_str[447:64], 1'b0);
    tick();
    chk1("run_ce", bf_ce, 1'b1);
    chk1("run_zero_string", bf_reset_zero_string, 1'b0);
    chk1("run_bf_reset", bf_reset, 1'b0);
    rd(R_STATUS, 32'h01, "status_busy");
    wr(R_HASH_A, 32'hdeadbeef);
    rd(R_HASH_A, 32'h4c71fce2, "hash_a_busy_write");
    wr(R_CTRL, 32'h2);
    chk1("abort_ce", bf_ce, 1'b0);
    chk1("abort_irq", irq, 1'b1);
    rd(R_STATUS, 32'h08, "status_aborted");

    // P=3 "abc" job finds "abcwxyz"
    wr(R_PLEN, 32'd3);
    wr(R_PFX0, 32'h00636261);
    wr(R_CTRL, 32'h1);
    chk1("abc_irq_cleared", irq, 1'b0);
    chk("abc_block_lo", bf_start_str[63:0], 64'h80202020_20636261);
    chk("abc_block_len", bf_start_str[511:448], 64'h38);
    tick();
    repeat (3) tick();
    bf_result_str = res1; bf_find_str = 1'b1;
    tick();
    bf_find_str = 1'b0; bf_result_str = '0;
    chk1("found_ce", bf_ce, 1'b0);
    chk1("found_irq", irq, 1'b1);
    chk1("found_bf_reset", bf_reset, 1'b1);
    rd(R_STATUS, 32'h02, "status_found");
    rd(R_RES0, 32'h77636261, "result_w0");
    rd(R_RES1, 32'h807a7978, "result_w1");
    rd(R_RES14, 32'h00000038, "result_w14");
    rd(R_CYCLES, CYC_JOB2, "cycles_found_job");
    rd(6'h08, 32'h0, "unmapped_read");
    rd(R_CTRL, 32'h0, "ctrl_write_only");

    // Exhausted job keeps previous result
    wr(R_CTRL, 32'h1);
    tick();
    bf_symbols_done = 1'b1;
    tick();
    bf_symbols_done = 1'b0;
    chk1("exhausted_irq", irq, 1'b1);
    rd(R_STATUS, 32'h04, "status_exhausted");
    rd(R_RES0, 32'h77636261, "result_kept");

    // find + done + abort together: find wins
    wr(R_CTRL, 32'h1);
    tick();
    bf_find_str = 1'b1; bf_symbols_done = 1'b1; bf_result_str = res2;
    wr_en = 1'b1; addr = R_CTRL; wr_data = 32'h2;
    tick();
    bf_find_str = 1'b0; bf_symbols_done = 1'b0; bf_result_str = '0; wr_en = 1'b0;
    rd(R_STATUS, 32'h02, "status_priority");
    rd(R_RES0, 32'h11223344, "result_priority");

    // Async reset mid-RUN
    wr(R_CTRL, 32'h1);
    tick();
    chk1("pre_reset_ce", bf_ce, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("async_reset_ce", bf_ce, 1'b0);
    chk1("async_reset_bf_reset", bf_reset, 1'b1);
    chk1("async_reset_block", |bf_start_str, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    rd(R_STATUS, 32'h0, "status_post_reset");
    rd(R_HASH_A, 32'h0, "hash_a_post_reset");
    rd(R_HASH_D, 32'h0, "hash_d_post_reset");
    rd(R_PLEN, 32'h0, "plen_post_reset");
    rd(R_PFX0, 32'h0, "prefix0_post_reset");
    rd(R_RES0, 32'h0, "result0_post_reset");

    // Job after reset runs normally
    wr(R_CTRL, 32'h1);
    chk1("post_reset_arm", bf_reset_zero_string, 1'b1);
    chk("post_reset_block", bf_start_str[63:0], 64'h00000080_20202020);
    tick();
    chk1("post_reset_run_ce", bf_ce, 1'b1);
    bf_symbols_done = 1'b1;
    tick();
    bf_symbols_done = 1'b0;
    rd(R_STATUS, 32'h04, "status_post_reset_job");
    rd(R_CYCLES, CYC_LAST, "cycles_last_job");

    tick(); tick(); tick();
    chk("read_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md5_job_ctrl.md
Name: md5_job_ctrl

Overview:
- Processor-facing job controller that sits directly upstream of the 4-symbol MD5 brute-force engine.
- Holds the target hash and the known message prefix in a small register file. Formats the padded single 512-bit MD5 block (prefix, four brute-force slots seeded with 0x20, 0x80 pad byte, bit length).
- Sequences the engine's ce/reset/reset_zero_string controls, then captures the found string or the exhausted status for software readback.

Parameters:
- ADDR_W, 6, register word-address width.
- MAX_PREFIX, 51, maximum prefix length in bytes (51 + 4 symbols + 0x80 pad + 8 length bytes = 64).
- SEED_CHAR, 8'h20, initial value written to each brute-force slot.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  register write strobe.
- rd_en  in  1  register read strobe.
- addr  in  ADDR_W  register word address.
- wr_data  in  32  write data.
- rd_data  out  32  read data, registered, 1-cycle latency.
- irq  out  1  level interrupt: FOUND, EXHAUSTED or ABORTED state.
- bf_ce  out  1  engine clock enable.
- bf_reset  out  1  engine reset.
- bf_reset_zero_string  out  1  engine zero-string restart.
- bf_start_str  out  512  padded MD5 block to the engine.
- bf_a_hash, bf_b_hash, bf_c_hash, bf_d_hash  out  32 each  target digest words, passed through unchanged.
- bf_find_str  in  1  engine match flag.
- bf_symbols_done  in  1  engine search-space-exhausted flag.
- bf_result_str  in  512  engine matching block, valid in the same cycle as bf_find_str.

Behaviour:
- Register map (word addresses):
  - 0x00 CTRL, write-only: bit0 start, bit1 abort. Both self-clearing.
  - 0x01 STATUS, read-only: bit0 busy, bit1 found, bit2 exhausted, bit3 aborted, bit4 len_err.
  - 0x02–0x05 HASH_A–HASH_D, read/write.
  - 0x06 PREFIX_LEN, read/write, bits [5:0].
  - 0x07 CYCLES (optional feature).
  - 0x10–0x1C PREFIX words 0–12, read/write.
  - 0x20–0x2F RESULT words 0–15, read-only.
  - Unmapped reads return 0.
- Byte order: message byte i maps to block[8i+7:8i]. Register word k holds bytes 4k..4k+3, little-endian.
- Block format, with P = PREFIX_LEN:
  - bytes 0..P-1 = prefix.
  - bytes P..P+3 = SEED_CHAR.
  - byte P+4 = 0x80.
  - remaining bytes = 0.
  - block[511:448] = 64-bit bit length, (P+4)*8, little-endian.
- The block is computed combinationally and latched into bf_start_str at an accepted start. bf_start_str is constant until the FSM returns to IDLE.
- FSM states: IDLE, ARM, RUN, FOUND, EXHAUSTED, ABORTED.
  - IDLE: bf_ce=0, bf_reset=1. A start with P ≤ MAX_PREFIX is accepted: clear sticky status, latch the block, go to ARM. A start with P > MAX_PREFIX sets len_err and stays in IDLE.
  - ARM (exactly 1 cycle): bf_reset=1, bf_reset_zero_string=1, bf_ce=0. Then go to RUN.
  - RUN: bf_ce=1, bf_reset=0, bf_reset_zero_string=0.
    - bf_find_str=1: latch bf_result_str into RESULT, go to FOUND.
    - otherwise bf_symbols_done=1: go to EXHAUSTED.
    - otherwise abort: go to ABORTED.
    - Priority is find > done > abort when these occur in the same cycle.
  - FOUND, EXHAUSTED, ABORTED: bf_ce=0, bf_reset=1, corresponding status bit set, irq=1. A new accepted start goes to ARM.
- busy = 1 in ARM or RUN.
  - Writes to HASH, PREFIX_LEN and PREFIX while busy are ignored.
  - Start while busy is ignored.
  - Abort outside RUN has no effect.
- Async reset:
  - Forces IDLE. Outputs: bf_ce=0, bf_reset=1, bf_reset_zero_string=0, bf_start_str=0, irq=0, rd_data=0.
  - All registers and sticky bits are cleared.
  - Reset mid-RUN drops bf_ce immediately (asynchronously).
- A write and a read to the same address in the same cycle return the old value.

Optional Feature:
- Macro: MD5_JOB_CYCLE_CNT_EN.
- Defined:
  - 32-bit CYCLES counter, cleared at an accepted start.
  - Increments every cycle in RUN and saturates at 0xFFFFFFFF.
  - Readable at 0x07.
- Undefined: no counter logic; 0x07 reads 0.

Decomposition:
- Package md5_job_pkg contains:
  - Register address localparams.
  - The FSM state enum.
  - MAX_PREFIX, BF_SYMBOLS=4, PAD_BYTE=8'h80.
  - STATUS bit-index localparams.
- One combinational sub-module, md5_pad_block: inputs are the prefix bytes and P; output is the 512-bit formatted block.

Test Plan:
- P=0, HASH = 4c71fce2/93ee2747/cd24f395/1f337f2e, start → bf_start_str bytes 0–3 = 0x20, byte4 = 0x80, byte56 = 0x20, all other bytes 0; ARM lasts 1 cycle with bf_reset_zero_string=1; bf_ce=1 from the next cycle.
- P=3, prefix "abc", engine model asserts bf_find_str with result "abcwxyz" → STATUS=0x02, irq=1, bf_ce=0 next cycle, RESULT word0 = 0x77636261.
- Engine model asserts bf_symbols_done → STATUS=0x04, RESULT unchanged from the previous job.
- bf_find_str and bf_symbols_done asserted in the same cycle → FOUND (0x02); abort written in that same cycle is ignored.
- PREFIX_LEN=52, start → STATUS=0x10, FSM stays in IDLE, bf_ce never asserted. Abort mid-RUN → STATUS=0x08. Write HASH_A while busy → readback unchanged.
- Assert reset mid-RUN → bf_ce=0 in the same cycle, STATUS=0, all registers read 0; a subsequent start runs normally. With MD5_JOB_CYCLE_CNT_EN, CYCLES equals the count of RUN cycles.
